// File: rtl/wb_master_interface.sv
`default_nettype none
// ============================================================================
//  Module   : wb_master_interface
//  Purpose  : Wishbone pipelined-mode initiator. Turns one core-side request
//             (enable/busy handshake) into one Wishbone classic-pipelined
//             transaction, with a bus timeout so an unmapped address ends in
//             an error instead of hanging the core.
//  Ports    : wb_clk_i / wb_rst_i        clock, async active-low reset
//             core*                      core request / response port
//             wb_*_o                     registered Wishbone initiator outputs
//             wb_ack_i/stall_i/error_i/data_i  Wishbone responder inputs
//  Revision : 1.0  initial release
// ============================================================================
module wb_master_interface #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  // core side
  input  logic [ADDRESS_WIDTH-1:0] coreAddress,
  input  logic [3:0]               coreByteSelect,
  input  logic                     coreEnable,
  input  logic                     coreWriteEnable,
  input  logic [31:0]              coreDataWrite,
  output logic [31:0]              coreDataRead,
  output logic                     coreBusy,
  output logic                     coreError,
  // wishbone side
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [3:0]               wb_sel_o,
  output logic [ADDRESS_WIDTH-1:0] wb_adr_o,
  output logic [31:0]              wb_data_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_stall_i,
  input  logic                     wb_error_i,
  input  logic [31:0]              wb_data_i
);

  // Counter wide enough to hold TIMEOUT_CYCLES; a 1-bit stub when disabled.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [31:0]      ERR_DATA    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic                     cyc_q, cyc_d;
  logic                     stb_q, stb_d;
  logic                     we_q, we_d;
  logic [3:0]               sel_q, sel_d;
  logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
  logic [31:0]              data_q, data_d;
  logic [31:0]              read_buf_q, read_buf_d;
  logic                     error_q, error_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic [CNT_W-1:0]         cnt_inc;
  logic                     timeout_hit;
  logic                     bus_exit;

  // Saturating increment; the timeout fires on the cycle the incremented
  // count would reach the limit, so the bus is held for exactly
  // TIMEOUT_CYCLES cycles across REQUEST and WAIT_ACK.
  assign cnt_inc     = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc >= TIMEOUT_VAL);

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    data_d     = data_q;
    read_buf_d = read_buf_q;
    error_d    = error_q;
    count_d    = count_q;
    bus_exit   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (coreEnable) begin
          adr_d   = coreAddress;
          sel_d   = coreByteSelect;
          we_d    = coreWriteEnable;
          data_d  = coreWriteEnable ? coreDataWrite : 32'h0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          count_d = '0;
          error_d = 1'b0;
          state_d = ST_REQUEST;
        end
      end

      ST_REQUEST: begin
        // ack/error cannot belong to this request yet, so they are ignored.
        count_d = cnt_inc;
        if (timeout_hit) begin
          error_d    = 1'b1;
          read_buf_d = ERR_DATA;
          bus_exit   = 1'b1;
        end else if (!wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        count_d = cnt_inc;
        // Error wins over a simultaneous ack; timeout only if neither came.
        if (wb_error_i || (!wb_ack_i && timeout_hit)) begin
          error_d    = 1'b1;
          read_buf_d = ERR_DATA;
          bus_exit   = 1'b1;
        end else if (wb_ack_i) begin
          if (!we_q) read_buf_d = wb_data_i;
          bus_exit = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any exit from a bus state returns the Wishbone outputs to idle values.
    if (bus_exit) begin
      state_d = ST_DONE;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      we_d    = 1'b0;
      sel_d   = 4'h0;
      adr_d   = '0;
      data_d  = 32'h0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q    <= ST_IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      adr_q      <= '0;
      data_q     <= 32'h0;
      read_buf_q <= ERR_DATA;
      error_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      data_q     <= data_d;
      read_buf_q <= read_buf_d;
      error_q    <= error_d;
      count_q    <= count_d;
    end
  end

  // Busy is combinational so the core sees it in the same cycle it raises
  // enable while the interface is idle.
  always_comb begin
    coreBusy = 1'b0;
    case (state_q)
      ST_IDLE:     coreBusy = coreEnable;
      ST_REQUEST:  coreBusy = 1'b1;
      ST_WAIT_ACK: coreBusy = 1'b1;
      ST_DONE:     coreBusy = 1'b0;
      default:     coreBusy = 1'b0;
    endcase
  end

  assign coreDataRead = read_buf_q;
  assign coreError    = error_q;

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_adr_o  = adr_q;
  assign wb_data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_interface.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_master_interface
//  Purpose  : Self-checking bench for wb_master_interface. A behavioural
//             Wishbone responder is stepped once per clock; expected core
//             results are queued when a request is issued and popped when the
//             interface reports completion.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_master_interface;

  localparam int AW       = 32;
  localparam int TMO      = 8;
  localparam int RSP_ACK  = 0;
  localparam int RSP_ERR  = 1;
  localparam int RSP_NONE = 2;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] coreAddress;
  logic [3:0]    coreByteSelect;
  logic          coreEnable;
  logic          coreWriteEnable;
  logic [31:0]   coreDataWrite;
  logic [31:0]   coreDataRead;
  logic          coreBusy;
  logic          coreError;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]    wb_sel_o;
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   wb_data_o;
  logic          wb_ack_i, wb_stall_i, wb_error_i;
  logic [31:0]   wb_data_i;

  wb_master_interface #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst_n),
    .coreAddress    (coreAddress),
    .coreByteSelect (coreByteSelect),
    .coreEnable     (coreEnable),
    .coreWriteEnable(coreWriteEnable),
    .coreDataWrite  (coreDataWrite),
    .coreDataRead   (coreDataRead),
    .coreBusy       (coreBusy),
    .coreError      (coreError),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_sel_o       (wb_sel_o),
    .wb_adr_o       (wb_adr_o),
    .wb_data_o      (wb_data_o),
    .wb_ack_i       (wb_ack_i),
    .wb_stall_i     (wb_stall_i),
    .wb_error_i     (wb_error_i),
    .wb_data_i      (wb_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rsp_q[$];
  logic [31:0] model_rbuf;

  int n_cmp = 0;
  int n_bad = 0;

  // responder configuration and monitor state
  int          rsp_mode;
  int          stall_left;
  int          stb_cycles, cyc_cycles, cyc_rises, field_errs;
  logic        prev_cyc;
  logic [AW-1:0] exp_adr;
  logic [3:0]  exp_sel;
  logic        exp_we;
  logic [31:0] exp_wdata;

  // Advance one clock; inputs are updated 1 time unit after the edge and the
  // monitor samples the post-edge register outputs at the same point.
  task automatic tick();
    logic pre_stb, pre_stall;
    pre_stb   = wb_stb_o;
    pre_stall = wb_stall_i;
    @(posedge clk);
    #1;
    if (pre_stb && pre_stall && stall_left > 0) stall_left--;
    wb_ack_i   = 1'b0;
    wb_error_i = 1'b0;
    wb_data_i  = 32'h0;
    if (pre_stb && !pre_stall) begin
      if (rsp_mode != RSP_NONE && rsp_q.size() > 0) begin
        wb_ack_i  = 1'b1;
        wb_data_i = rsp_q.pop_front();
        if (rsp_mode == RSP_ERR) wb_error_i = 1'b1;
      end
    end
    wb_stall_i = wb_stb_o && (stall_left > 0);
    if (wb_stb_o) begin
      stb_cycles++;
      if (wb_adr_o !== exp_adr || wb_sel_o !== exp_sel ||
          wb_we_o !== exp_we || wb_data_o !== exp_wdata) field_errs++;
    end
    if (wb_cyc_o) cyc_cycles++;
    if (wb_cyc_o && !prev_cyc) cyc_rises++;
    prev_cyc = wb_cyc_o;
  endtask

  task automatic clear_mon();
    stb_cycles = 0; cyc_cycles = 0; cyc_rises = 0; field_errs = 0;
  endtask

  // Present a request; the bench's own model decides what should come back.
  task automatic issue(input logic [AW-1:0] adr, input logic [3:0] sel,
                       input logic we, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int mode);
    coreAddress     = adr;
    coreByteSelect  = sel;
    coreWriteEnable = we;
    coreDataWrite   = wdata;
    coreEnable      = 1'b1;
    exp_adr   = adr;
    exp_sel   = sel;
    exp_we    = we;
    exp_wdata = we ? wdata : 32'h0;
    rsp_mode  = mode;
    if (mode != RSP_NONE) rsp_q.push_back(rdata);
    if (mode == RSP_ACK) begin
      if (!we) model_rbuf = rdata;
      exp_q.push_back('{data: model_rbuf, err: 1'b0});
    end else begin
      model_rbuf = 32'hFFFF_FFFF;
      exp_q.push_back('{data: model_rbuf, err: 1'b1});
    end
  endtask

  // Clock until coreBusy drops; -1 if the bound expires.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (coreBusy && n < 40);
    if (coreBusy) n = -1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    coreEnable = 0; coreAddress = '0; coreByteSelect = 0; coreWriteEnable = 0;
    coreDataWrite = 0; wb_ack_i = 0; wb_stall_i = 0; wb_error_i = 0; wb_data_i = 0;
    rsp_mode = RSP_ACK; stall_left = 0; prev_cyc = 0; model_rbuf = 32'hFFFF_FFFF;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    if (wb_cyc_o !== 1'b0) begin n_bad++; $display("FAIL reset_cyc: got %b exp 0", wb_cyc_o); end
    n_cmp++;
    if (wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_stb_we: got %b%b exp 00", wb_stb_o, wb_we_o); end
    n_cmp++;
    if (wb_adr_o !== '0 || wb_sel_o !== 4'h0 || wb_data_o !== 32'h0) begin
      n_bad++; $display("FAIL reset_adr_sel_data: got %h %h %h exp 0", wb_adr_o, wb_sel_o, wb_data_o); end
    n_cmp++;
    if (coreDataRead !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL reset_rdata: got %h exp ffffffff", coreDataRead); end
    n_cmp++;
    if (coreError !== 1'b0 || coreBusy !== 1'b0) begin
      n_bad++; $display("FAIL reset_err_busy: got %b%b exp 00", coreError, coreBusy); end
    n_cmp++;
    e.data = 0; // silence unused-variable paths
  endtask

  task automatic test_read();
    int n; exp_t e;
    clear_mon();
    issue(32'h0000_0010, 4'hF, 1'b0, 32'h0, 32'hDEAD_BEEF, RSP_ACK);
    wait_done(n);
    coreEnable = 1'b0;
    e = exp_q.pop_front();
    if (n !== 3) begin n_bad++; $display("FAIL read_latency: got %0d exp 3", n); end
    n_cmp++;
    if (stb_cycles !== 1) begin n_bad++; $display("FAIL read_stb_len: got %0d exp 1", stb_cycles); end
    n_cmp++;
    if (coreDataRead !== e.data) begin
      n_bad++; $display("FAIL read_data: got %h exp %h", coreDataRead, e.data); end
    n_cmp++;
    if (coreError !== e.err) begin n_bad++; $display("FAIL read_err: got %b exp %b", coreError, e.err); end
    n_cmp++;
    tick();
  endtask

  task automatic test_write_stall();
    int n; exp_t e;
    clear_mon();
    stall_left = 3;
    issue(32'h0000_0020, 4'h3, 1'b1, 32'h1234_5678, 32'h55AA_55AA, RSP_ACK);
    wait_done(n);
    coreEnable = 1'b0;
    e = exp_q.pop_front();
    if (n !== 6) begin n_bad++; $display("FAIL write_latency: got %0d exp 6", n); end
    n_cmp++;
    if (stb_cycles !== 4) begin n_bad++; $display("FAIL write_stb_len: got %0d exp 4", stb_cycles); end
    n_cmp++;
    if (field_errs !== 0) begin n_bad++; $display("FAIL write_fields_stable: got %0d bad cycles exp 0", field_errs); end
    n_cmp++;
    if (coreError !== e.err) begin n_bad++; $display("FAIL write_err: got %b exp %b", coreError, e.err); end
    n_cmp++;
    if (coreDataRead !== e.data) begin
      n_bad++; $display("FAIL write_rbuf_kept: got %h exp %h", coreDataRead, e.data); end
    n_cmp++;
    if (wb_data_o !== 32'h0 || wb_cyc_o !== 1'b0 || wb_we_o !== 1'b0) begin
      n_bad++; $display("FAIL write_done_bus_idle: got data %h cyc %b we %b exp 0", wb_data_o, wb_cyc_o, wb_we_o); end
    n_cmp++;
    tick();
  endtask

  task automatic test_error();
    int n; exp_t e;
    clear_mon();
    issue(32'h0000_0030, 4'hF, 1'b0, 32'h0, 32'h1111_2222, RSP_ERR);
    wait_done(n);
    coreEnable = 1'b0;
    e = exp_q.pop_front();
    if (n !== 3) begin n_bad++; $display("FAIL error_latency: got %0d exp 3", n); end
    n_cmp++;
    if (coreError !== e.err) begin n_bad++; $display("FAIL error_flag: got %b exp %b", coreError, e.err); end
    n_cmp++;
    if (coreDataRead !== e.data) begin
      n_bad++; $display("FAIL error_data: got %h exp %h", coreDataRead, e.data); end
    n_cmp++;
    tick();
  endtask

  task automatic test_timeout();
    int n; exp_t e;
    clear_mon();
    issue(32'hDEAD_0000, 4'hF, 1'b0, 32'h0, 32'h0, RSP_NONE);
    wait_done(n);
    coreEnable = 1'b0;
    e = exp_q.pop_front();
    if (n !== TMO + 1) begin n_bad++; $display("FAIL timeout_latency: got %0d exp %0d", n, TMO + 1); end
    n_cmp++;
    if (cyc_cycles !== TMO) begin n_bad++; $display("FAIL timeout_cyc_len: got %0d exp %0d", cyc_cycles, TMO); end
    n_cmp++;
    if (coreError !== e.err) begin n_bad++; $display("FAIL timeout_err: got %b exp %b", coreError, e.err); end
    n_cmp++;
    if (coreDataRead !== e.data) begin
      n_bad++; $display("FAIL timeout_data: got %h exp %h", coreDataRead, e.data); end
    n_cmp++;
    tick();
    // a following request must complete normally
    issue(32'h0000_0040, 4'hF, 1'b0, 32'h0, 32'h1357_9BDF, RSP_ACK);
    wait_done(n);
    coreEnable = 1'b0;
    e = exp_q.pop_front();
    if (n !== 3) begin n_bad++; $display("FAIL after_timeout_latency: got %0d exp 3", n); end
    n_cmp++;
    if (coreError !== e.err || coreDataRead !== e.data) begin
      n_bad++; $display("FAIL after_timeout_result: got %b %h exp %b %h", coreError, coreDataRead, e.err, e.data); end
    n_cmp++;
    tick();
  endtask

  task automatic test_reset_mid();
    int n; exp_t e;
    clear_mon();
    issue(32'h0000_0050, 4'hF, 1'b0, 32'h0, 32'h0, RSP_NONE);
    tick();
    tick();
    if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin
      n_bad++; $display("FAIL midreset_in_wait_ack: got cyc %b stb %b exp 1 0", wb_cyc_o, wb_stb_o); end
    n_cmp++;
    #2;
    rst_n = 1'b0;
    #1;
    if (wb_cyc_o !== 1'b0) begin n_bad++; $display("FAIL midreset_cyc_async: got %b exp 0", wb_cyc_o); end
    n_cmp++;
    if (coreDataRead !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL midreset_rdata: got %h exp ffffffff", coreDataRead); end
    n_cmp++;
    // the aborted transaction will never report; drop its expectation
    void'(exp_q.pop_front());
    rsp_q.delete();
    model_rbuf = 32'hFFFF_FFFF;
    coreEnable = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_cyc = 1'b0;
    tick();
    issue(32'h0000_0060, 4'hF, 1'b0, 32'h0, 32'h0BAD_C0DE, RSP_ACK);
    wait_done(n);
    coreEnable = 1'b0;
    e = exp_q.pop_front();
    if (n !== 3) begin n_bad++; $display("FAIL postreset_latency: got %0d exp 3", n); end
    n_cmp++;
    if (coreError !== e.err || coreDataRead !== e.data) begin
      n_bad++; $display("FAIL postreset_result: got %b %h exp %b %h", coreError, coreDataRead, e.err, e.data); end
    n_cmp++;
    tick();
  endtask

  task automatic test_back_to_back();
    int n; exp_t e;
    logic [31:0] rd [3];
    rd[0] = 32'hA0A0_0001; rd[1] = 32'hB1B1_0002; rd[2] = 32'hC2C2_0003;
    clear_mon();
    issue(32'h0000_0100, 4'hF, 1'b0, 32'h0, rd[0], RSP_ACK);
    for (int i = 0; i < 3; i++) begin
      wait_done(n);
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL b2b_queue: got empty exp 1 entry"); end
      n_cmp++;
      e = exp_q.pop_front();
      if (n !== ((i == 0) ? 3 : 4)) begin
        n_bad++; $display("FAIL b2b_period_%0d: got %0d exp %0d", i, n, (i == 0) ? 3 : 4); end
      n_cmp++;
      if (coreDataRead !== e.data || coreError !== e.err) begin
        n_bad++; $display("FAIL b2b_result_%0d: got %h %b exp %h %b", i, coreDataRead, coreError, e.data, e.err); end
      n_cmp++;
      if (i < 2) issue(32'h0000_0104 + 32'(4 * i), 4'hF, 1'b0, 32'h0, rd[i+1], RSP_ACK);
      else coreEnable = 1'b0;
    end
    tick();
    if (cyc_rises !== 3) begin n_bad++; $display("FAIL b2b_cyc_count: got %0d exp 3", cyc_rises); end
    n_cmp++;
    if (stb_cycles !== 3) begin n_bad++; $display("FAIL b2b_stb_count: got %0d exp 3", stb_cycles); end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_error();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
